// File: rtl/dm_cache_refill.sv
// Miss-refill engine for a direct-mapped cache (256 lines x 64 B).
// It takes one line miss at a time and fetches the line as 16 word beats,
// with at most one memory read outstanding. Each beat is written into the
// data array as soon as it arrives. The tag is written last, so the cache
// can never hit on a partly filled line.
module dm_cache_refill #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 6,
    parameter int WORDS    = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 miss_valid,
    input  logic [ADDR_W-1:0]                    miss_addr,
    output logic                                 miss_ready,
    output logic                                 mem_req_valid,
    output logic [ADDR_W-1:0]                    mem_req_addr,
    input  logic                                 mem_req_ready,
    input  logic                                 mem_rsp_valid,
    input  logic [31:0]                          mem_rsp_data,
    output logic                                 fill_we,
    output logic [INDEX_W-1:0]                   fill_index,
    output logic [$clog2(WORDS)-1:0]             fill_word,
    output logic [31:0]                          fill_data,
    output logic                                 tag_we,
    output logic [ADDR_W-INDEX_W-OFFSET_W-1:0]   tag_data,
    output logic                                 refill_done,
    output logic [31:0]                          refill_count,
    output logic                                 rsp_error
);

    localparam int BEAT_W = $clog2(WORDS);
    localparam int LINE_W = ADDR_W - OFFSET_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t              state_q;
    logic [LINE_W-1:0]   base_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                miss_ready_q;
    logic                req_valid_q;
    logic                commit_q;
    logic [31:0]         count_q;
    logic                rsp_error_q;

    // The byte offset inside the line is not needed, because a refill always starts at word 0.
    logic                unused_offset;
    assign unused_offset = ^miss_addr[OFFSET_W-1:0];

    // Refill sequencer. The handshake outputs are registered and are set on the
    // same transition that enters the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            miss_ready_q <= 1'b1;
            req_valid_q  <= 1'b0;
            commit_q     <= 1'b0;
            count_q      <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            if (mem_rsp_valid && (state_q != WAIT)) begin
                rsp_error_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (miss_valid) begin
                        base_q       <= miss_addr[ADDR_W-1:OFFSET_W];
                        beat_q       <= '0;
                        miss_ready_q <= 1'b0;
                        req_valid_q  <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        if (beat_q == LAST_BEAT) begin
                            commit_q <= 1'b1;
                            state_q  <= COMMIT;
                        end else begin
                            beat_q      <= beat_q + 1'b1;
                            req_valid_q <= 1'b1;
                            state_q     <= REQ;
                        end
                    end
                end
                COMMIT: begin
                    count_q      <= count_q + 32'd1;
                    miss_ready_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The address is formed from the captured line base and the beat number,
    // so it cannot leave the line. fill_we follows the response combinationally.
    assign miss_ready    = miss_ready_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = {base_q, beat_q, {(OFFSET_W-BEAT_W){1'b0}}};
    assign fill_we       = (state_q == WAIT) && mem_rsp_valid;
    assign fill_index    = base_q[INDEX_W-1:0];
    assign fill_word     = beat_q;
    assign fill_data     = mem_rsp_data;
    assign tag_we        = commit_q;
    assign refill_done   = commit_q;
    assign tag_data      = base_q[LINE_W-1:INDEX_W];
    assign refill_count  = count_q;
    assign rsp_error     = rsp_error_q;

endmodule

// File: tb/tb_dm_cache_refill.sv
// Directed testbench for dm_cache_refill. A small memory responder answers
// each accepted read one cycle later and can stall a chosen address.
module tb_dm_cache_refill;

    logic        clk;
    logic        rst;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        miss_ready;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        fill_we;
    logic [7:0]  fill_index;
    logic [3:0]  fill_word;
    logic [31:0] fill_data;
    logic        tag_we;
    logic [17:0] tag_data;
    logic        refill_done;
    logic [31:0] refill_count;
    logic        rsp_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] stallAddr = 32'hFFFF_FFFF;
    int          stallLeft = 0;
    logic        spurious  = 1'b0;
    logic        pend      = 1'b0;
    logic [31:0] pendAddr  = '0;

    dm_cache_refill dut (
        .clk           (clk),
        .rst           (rst),
        .miss_valid    (miss_valid),
        .miss_addr     (miss_addr),
        .miss_ready    (miss_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .fill_we       (fill_we),
        .fill_index    (fill_index),
        .fill_word     (fill_word),
        .fill_data     (fill_data),
        .tag_we        (tag_we),
        .tag_data      (tag_data),
        .refill_done   (refill_done),
        .refill_count  (refill_count),
        .rsp_error     (rsp_error)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: each word is derived from its own address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory responder. It returns the data one cycle after an accepted request
    // and stalls the chosen address for stallLeft cycles.
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = pend | spurious;
            mem_rsp_data  = pend ? memWord(pendAddr) : 32'hBAD0_BAD0;
            pend          = 1'b0;
            spurious      = 1'b0;
            if (mem_req_valid && (stallLeft > 0) && (mem_req_addr == stallAddr)) begin
                mem_req_ready = 1'b0;
                stallLeft     = stallLeft - 1;
            end else begin
                mem_req_ready = 1'b1;
            end
            if (mem_req_valid && mem_req_ready && !rst) begin
                pend     = 1'b1;
                pendAddr = mem_req_addr;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #2;
    endtask

    // Runs one refill of addr and checks every cycle until the tag write.
    // holdNext keeps a second miss (nextAddr) waiting while this refill runs.
    // abortBeat >= 0 pulses rst after that beat has been filled.
    task automatic applyStimulus(input logic [31:0] addr, input int stallLen,
                                 input logic holdNext, input logic [31:0] nextAddr,
                                 input int abortBeat, input logic [31:0] expCount);
        logic [31:0] base;
        int          beat;
        int          cyc;
        logic        done;
        logic        aborted;
        base      = {addr[31:6], 6'b0};
        stallAddr = base + 32'h1C;
        stallLeft = stallLen;
        miss_valid = 1'b1;
        miss_addr  = addr;
        checkOutput("accept_ready", {31'd0, miss_ready}, 32'd1);
        nextCycle();
        if (holdNext) miss_addr = nextAddr;
        else miss_valid = 1'b0;
        beat    = 0;
        cyc     = 1;
        done    = 1'b0;
        aborted = 1'b0;
        while (!done && !aborted && cyc < 300) begin
            if (holdNext) checkOutput("busy_ready", {31'd0, miss_ready}, 32'd0);
            if (mem_req_valid) checkOutput("req_addr", mem_req_addr, base + 32'(4 * beat));
            if (tag_we) begin
                checkOutput("done_pulse", {31'd0, refill_done}, 32'd1);
                checkOutput("beats_before_tag", 32'(beat), 32'd16);
                checkOutput("tag_data", {14'd0, tag_data}, {14'd0, addr[31:14]});
                checkOutput("tag_index", {24'd0, fill_index}, {24'd0, addr[13:6]});
                checkOutput("latency", 32'(cyc + 1), 32'(34 + stallLen));
                done = 1'b1;
            end
            if (fill_we) begin
                checkOutput("fill_word", {28'd0, fill_word}, 32'(beat));
                checkOutput("fill_data", fill_data, memWord(base + 32'(4 * beat)));
                checkOutput("fill_index", {24'd0, fill_index}, {24'd0, addr[13:6]});
                if (beat == abortBeat) begin
                    rst     = 1'b1;
                    aborted = 1'b1;
                end
                beat++;
            end
            if (!done && !aborted) begin
                nextCycle();
                cyc++;
            end
        end
        if (aborted) begin
            nextCycle();
            rst = 1'b0;
            checkOutput("abort_ready", {31'd0, miss_ready}, 32'd1);
            checkOutput("abort_tag_we", {31'd0, tag_we}, 32'd0);
            checkOutput("abort_count", refill_count, 32'd0);
            checkOutput("abort_req_valid", {31'd0, mem_req_valid}, 32'd0);
            nextCycle();
            checkOutput("abort_tag_we_late", {31'd0, tag_we}, 32'd0);
        end else begin
            checkOutput("refill_finished", {31'd0, done}, 32'd1);
            nextCycle();
            checkOutput("count", refill_count, expCount);
            checkOutput("idle_ready", {31'd0, miss_ready}, 32'd1);
            checkOutput("done_one_cycle", {31'd0, refill_done}, 32'd0);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        nextCycle();
        nextCycle();
        rst = 1'b0;
    endtask

    // Directed sequence covering reset, plain refill, back-pressure, a busy
    // engine, reset during a refill, and a spurious memory response.
    initial begin
        rst        = 1'b1;
        miss_valid = 1'b0;
        miss_addr  = '0;
        doReset();

        $display("[TB] reset state");
        checkOutput("rst_ready", {31'd0, miss_ready}, 32'd1);
        checkOutput("rst_count", refill_count, 32'd0);
        checkOutput("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("rst_fill_we", {31'd0, fill_we}, 32'd0);
        checkOutput("rst_tag_we", {31'd0, tag_we}, 32'd0);
        checkOutput("rst_done", {31'd0, refill_done}, 32'd0);
        checkOutput("rst_rsp_error", {31'd0, rsp_error}, 32'd0);

        $display("[TB] single refill");
        applyStimulus(32'h0001_2345, 0, 1'b0, 32'd0, -1, 32'd1);
        checkOutput("hold_index_8d", {24'd0, fill_index}, 32'h8D);
        checkOutput("hold_tag_4", {14'd0, tag_data}, 32'h4);

        $display("[TB] back-pressure on beat 7");
        applyStimulus(32'h8000_0040, 5, 1'b0, 32'd0, -1, 32'd2);

        $display("[TB] busy engine with a queued miss");
        doReset();
        applyStimulus(32'h1234_5678, 0, 1'b1, 32'hCAFE_0F00, -1, 32'd1);
        applyStimulus(32'hCAFE_0F00, 0, 1'b0, 32'd0, -1, 32'd2);
        checkOutput("busy_second_tag", {14'd0, tag_data}, 32'h32BF8);

        $display("[TB] reset during refill");
        applyStimulus(32'h0ABC_DEF0, 0, 1'b0, 32'd0, 9, 32'd0);
        applyStimulus(32'h0000_3FC0, 0, 1'b0, 32'd0, -1, 32'd1);
        checkOutput("after_abort_index_ff", {24'd0, fill_index}, 32'hFF);

        $display("[TB] spurious response while idle");
        spurious = 1'b1;
        nextCycle();
        checkOutput("spur_fill_we", {31'd0, fill_we}, 32'd0);
        nextCycle();
        checkOutput("spur_rsp_error", {31'd0, rsp_error}, 32'd1);
        applyStimulus(32'h0001_2345, 0, 1'b0, 32'd0, -1, 32'd2);
        checkOutput("rsp_error_sticky", {31'd0, rsp_error}, 32'd1);
        doReset();
        checkOutput("rsp_error_cleared", {31'd0, rsp_error}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
